// File: rtl/packet_scheduler.sv
// Slot-based round-robin scheduler: a TICK snapshots the requesters, which are then
// granted the shared transmitter one at a time until the snapshot is drained.
module packet_scheduler #(
  parameter int          NUM_REQ     = 4,
  parameter int unsigned TIMEOUT_MAX = 32'd2499999
) (
  input  logic               CLK,
  input  logic               RESET,
  input  logic               ENABLE,
  input  logic               TICK,
  input  logic [NUM_REQ-1:0] REQ,
  input  logic               TX_BUSY,
  input  logic               TX_DONE,
  output logic [NUM_REQ-1:0] GRANT,
  output logic [1:0]         SEL,
  output logic               SEND_PACKET,
  output logic               TIMEOUT_ERR,
  output logic [7:0]         MISSED_CNT,
  output logic [1:0]         STATE_DBG
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] ARB  = 2'd1;
  localparam logic [1:0] SEND = 2'd2;
  localparam logic [1:0] WAIT = 2'd3;

  // Transmitter handshake: SEND_PACKET is a one-cycle start issued only while
  // TX_BUSY is low; the transaction ends on a one-cycle TX_DONE or on timeout.
  logic [1:0]         state;
  logic [NUM_REQ-1:0] pending;
  logic [1:0]         last;
  logic [31:0]        timer;
  logic               pick_valid;
  logic [1:0]         pick_idx;
  logic [1:0]         cand;

  assign STATE_DBG = state;

  // Search begins just after the previous owner; i == NUM_REQ wraps back to it.
  always_comb begin
    pick_valid = 1'b0;
    pick_idx   = last;
    cand       = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      cand = last + 2'(i);
      if (!pick_valid && pending[cand]) begin
        pick_valid = 1'b1;
        pick_idx   = cand;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state       <= IDLE;
      pending     <= '0;
      last        <= 2'd3;
      timer       <= '0;
      GRANT       <= '0;
      SEL         <= '0;
      SEND_PACKET <= 1'b0;
      TIMEOUT_ERR <= 1'b0;
      MISSED_CNT  <= '0;
    end else begin
      SEND_PACKET <= 1'b0;
      if (TICK && state != IDLE && MISSED_CNT != 8'hFF) begin
        MISSED_CNT <= MISSED_CNT + 8'd1;
      end
      case (state)
        IDLE: begin
          if (TICK && ENABLE) begin
            pending <= REQ;
            state   <= ARB;
          end
        end
        ARB: begin
          if (!pick_valid || !ENABLE) begin
            GRANT <= '0;
            state <= IDLE;
          end else begin
            GRANT <= {{(NUM_REQ-1){1'b0}}, 1'b1} << pick_idx;
            SEL   <= pick_idx;
            state <= SEND;
          end
        end
        SEND: begin
          if (!TX_BUSY) begin
            SEND_PACKET <= 1'b1;
            timer       <= '0;
            state       <= WAIT;
          end
        end
        WAIT: begin
          // A TX_DONE coinciding with the limit counts as a normal completion.
          if (TX_DONE || timer == TIMEOUT_MAX) begin
            if (!TX_DONE) TIMEOUT_ERR <= 1'b1;
            pending[SEL] <= 1'b0;
            last         <= SEL;
            GRANT        <= '0;
            state        <= ARB;
          end else begin
            timer <= timer + 32'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_packet_scheduler.sv
// Directed bench for packet_scheduler: expected grant order is queued when a TICK is
// driven and compared against every SEND_PACKET pulse.
module tb_packet_scheduler;

  logic       CLK;
  logic       RESET;
  logic       ENABLE;
  logic       TICK;
  logic [3:0] REQ;
  logic       TX_BUSY;
  logic       TX_DONE;
  logic [3:0] GRANT;
  logic [1:0] SEL;
  logic       SEND_PACKET;
  logic       TIMEOUT_ERR;
  logic [7:0] MISSED_CNT;
  logic [1:0] STATE_DBG;

  int checks   = 0;
  int failures = 0;
  int sent_cnt = 0;
  logic prev_send = 1'b0;
  logic [1:0] exp_q[$];

  packet_scheduler #(.NUM_REQ(4), .TIMEOUT_MAX(15)) dut (
    .CLK(CLK), .RESET(RESET), .ENABLE(ENABLE), .TICK(TICK), .REQ(REQ),
    .TX_BUSY(TX_BUSY), .TX_DONE(TX_DONE), .GRANT(GRANT), .SEL(SEL),
    .SEND_PACKET(SEND_PACKET), .TIMEOUT_ERR(TIMEOUT_ERR),
    .MISSED_CNT(MISSED_CNT), .STATE_DBG(STATE_DBG)
  );

  // clock / reset
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // driver tasks
  task automatic step();
    @(negedge CLK);
    #1;
  endtask

  task automatic tick();
    TICK = 1'b1;
    step();
    TICK = 1'b0;
  endtask

  task automatic done();
    TX_DONE = 1'b1;
    step();
    TX_DONE = 1'b0;
  endtask

  task automatic wait_send(input int budget);
    int s;
    int n;
    s = sent_cnt;
    n = 0;
    while (sent_cnt == s && n < budget) begin
      step();
      n++;
    end
    check("wait_send", 32'(sent_cnt - s), 32'd1);
  endtask

  // scoreboard: every start pulse must match the next queued requester
  always @(negedge CLK) begin
    if (RESET) begin
      prev_send = 1'b0;
    end else begin
      if (SEND_PACKET) begin
        logic [1:0] e;
        sent_cnt++;
        check("send_single_cycle", 32'(prev_send), 32'd0);
        check("send_grant_onehot", 32'($countones(GRANT)), 32'd1);
        if (exp_q.size() == 0) begin
          check("sb_nonempty", 32'(exp_q.size()), 32'd1);
        end else begin
          e = exp_q.pop_front();
          check("sb_sel", 32'(SEL), 32'(e));
          check("sb_grant", 32'(GRANT), 32'(4'd1 << e));
        end
      end
      prev_send = SEND_PACKET;
    end
  end

  initial begin
    RESET = 1'b1; ENABLE = 1'b1; TICK = 1'b0; REQ = '0; TX_BUSY = 1'b0; TX_DONE = 1'b0;
    repeat (3) step();
    check("rst_grant", 32'(GRANT), 32'd0);
    check("rst_sel", 32'(SEL), 32'd0);
    check("rst_send", 32'(SEND_PACKET), 32'd0);
    check("rst_terr", 32'(TIMEOUT_ERR), 32'd0);
    check("rst_missed", 32'(MISSED_CNT), 32'd0);
    check("rst_state", 32'(STATE_DBG), 32'd0);
    RESET = 1'b0;
    step();

    // two requesters, exact latency; REQ dropped after snapshot
    REQ = 4'b0101;
    exp_q.push_back(2'd0);
    exp_q.push_back(2'd2);
    tick();
    REQ = 4'b0000;
    check("k0_grant", 32'(GRANT), 32'd0);
    check("k0_state", 32'(STATE_DBG), 32'd1);
    step();
    check("k1_grant", 32'(GRANT), 32'b0001);
    check("k1_send", 32'(SEND_PACKET), 32'd0);
    step();
    check("k2_send", 32'(SEND_PACKET), 32'd1);
    step();
    check("k3_send", 32'(SEND_PACKET), 32'd0);
    done();
    check("done_grant", 32'(GRANT), 32'd0);
    wait_send(10);
    done();
    step();
    check("pair_idle", 32'(STATE_DBG), 32'd0);
    check("pair_grant", 32'(GRANT), 32'd0);
    check("pair_sel_hold", 32'(SEL), 32'd2);

    // TX_DONE in IDLE and TICK with ENABLE low are both ignored
    done();
    check("stray_done_state", 32'(STATE_DBG), 32'd0);
    check("stray_done_sel", 32'(SEL), 32'd2);
    ENABLE = 1'b0;
    REQ = 4'b1111;
    tick();
    step();
    check("dis_tick_state", 32'(STATE_DBG), 32'd0);
    check("dis_tick_missed", 32'(MISSED_CNT), 32'd0);
    ENABLE = 1'b1;

    // round robin continues after LAST=2
    REQ = 4'b1111;
    exp_q.push_back(2'd3);
    exp_q.push_back(2'd0);
    exp_q.push_back(2'd1);
    exp_q.push_back(2'd2);
    tick();
    REQ = 4'b0000;
    repeat (4) begin
      wait_send(10);
      step();
      step();
      done();
    end
    step();
    check("rr_idle", 32'(STATE_DBG), 32'd0);

    // transmitter busy holds SEND
    REQ = 4'b0010;
    exp_q.push_back(2'd1);
    TX_BUSY = 1'b1;
    tick();
    step();
    for (int i = 0; i < 10; i++) begin
      check("busy_grant", 32'(GRANT), 32'b0010);
      check("busy_send", 32'(SEND_PACKET), 32'd0);
      step();
    end
    TX_BUSY = 1'b0;
    step();
    check("busy_release_send", 32'(SEND_PACKET), 32'd1);
    done();
    step();

    // TX_DONE on the limit cycle, then a real timeout
    REQ = 4'b0110;
    exp_q.push_back(2'd2);
    exp_q.push_back(2'd1);
    tick();
    REQ = 4'b0000;
    wait_send(10);
    repeat (15) step();
    TX_DONE = 1'b1;
    step();
    TX_DONE = 1'b0;
    check("edge_done_terr", 32'(TIMEOUT_ERR), 32'd0);
    check("edge_done_grant", 32'(GRANT), 32'd0);
    wait_send(10);
    repeat (15) step();
    check("pre_timeout_terr", 32'(TIMEOUT_ERR), 32'd0);
    check("pre_timeout_grant", 32'(GRANT), 32'b0010);
    step();
    check("timeout_terr", 32'(TIMEOUT_ERR), 32'd1);
    check("timeout_grant", 32'(GRANT), 32'd0);
    step();
    check("timeout_idle", 32'(STATE_DBG), 32'd0);

    // missed TICKs saturate while stuck in SEND
    REQ = 4'b0001;
    exp_q.push_back(2'd0);
    TX_BUSY = 1'b1;
    tick();
    step();
    for (int i = 0; i < 300; i++) begin
      TICK = 1'b1;
      step();
      TICK = 1'b0;
      step();
      if (i == 0) check("missed_first", 32'(MISSED_CNT), 32'd1);
      if (i == 254) check("missed_sat", 32'(MISSED_CNT), 32'd255);
    end
    check("missed_nowrap", 32'(MISSED_CNT), 32'd255);
    check("missed_state", 32'(STATE_DBG), 32'd2);

    // reset while waiting for TX_DONE
    TX_BUSY = 1'b0;
    step();
    check("pre_rst_send", 32'(SEND_PACKET), 32'd1);
    step();
    check("pre_rst_state", 32'(STATE_DBG), 32'd3);
    RESET = 1'b1;
    step();
    check("mid_rst_grant", 32'(GRANT), 32'd0);
    check("mid_rst_sel", 32'(SEL), 32'd0);
    check("mid_rst_send", 32'(SEND_PACKET), 32'd0);
    check("mid_rst_terr", 32'(TIMEOUT_ERR), 32'd0);
    check("mid_rst_missed", 32'(MISSED_CNT), 32'd0);
    check("mid_rst_state", 32'(STATE_DBG), 32'd0);
    RESET = 1'b0;
    REQ = 4'b1001;
    exp_q.push_back(2'd0);
    exp_q.push_back(2'd3);
    tick();
    REQ = 4'b0000;
    wait_send(10);
    done();
    wait_send(10);
    done();
    step();

    // ENABLE dropped mid-transaction: finish it, then stop
    REQ = 4'b0011;
    exp_q.push_back(2'd0);
    tick();
    REQ = 4'b0000;
    wait_send(10);
    ENABLE = 1'b0;
    step();
    done();
    check("dis_arb_state", 32'(STATE_DBG), 32'd1);
    step();
    check("dis_idle_state", 32'(STATE_DBG), 32'd0);
    check("dis_idle_grant", 32'(GRANT), 32'd0);
    begin
      int s;
      s = sent_cnt;
      repeat (5) step();
      check("dis_no_send", 32'(sent_cnt - s), 32'd0);
    end
    ENABLE = 1'b1;

    check("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
